// File: rtl/fixedpoint_inv.sv
// Sequential shift-add multiply by the Q1.8 constant K (1/ln2),
// with round-half-up and saturation to 8 bits.
module fixedpoint_inv #(
  parameter logic [8:0] K = 9'd369
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] int_in,
  input  logic       in_valid,
  output logic       in_ready,
  output logic [7:0] result,
  output logic       ovf,
  output logic       out_valid,
  input  logic       out_ready
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [7:0]  op_q, op_d;
  logic [16:0] acc_q, acc_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [7:0]  result_q, result_d;
  logic        ovf_q, ovf_d;

  logic [16:0] addend;
  logic [16:0] rnd_sum;
  logic [8:0]  rnd;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      op_q     <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      result_q <= '0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      ovf_q    <= ovf_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    ovf_d    = ovf_q;
    addend   = '0;
    rnd_sum  = '0;
    rnd      = '0;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          op_d    = int_in;
          acc_d   = '0;
          cnt_d   = '0;
          state_d = CALC;
        end
      end
      CALC: begin
        if (op_q[cnt_q]) begin
          addend = {8'd0, K} << cnt_q;
        end
        acc_d = acc_q + addend;
        cnt_d = cnt_q + 3'd1;
        if (cnt_q == 3'd7) begin
          // acc_d <= 94095, so adding 128 cannot wrap 17 bits
          rnd_sum  = acc_d + 17'd128;
          rnd      = rnd_sum[16:8];
          state_d  = DONE;
          if (rnd[8]) begin
            result_d = 8'hff;
            ovf_d    = 1'b1;
          end else begin
            result_d = rnd[7:0];
            ovf_d    = 1'b0;
          end
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign result    = result_q;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_fixedpoint_inv.sv
// Scoreboard bench for fixedpoint_inv: directed vectors,
// backpressure, ignored input, and reset scenarios.
module tb_fixedpoint_inv;

  logic       clk;
  logic       rst;
  logic [7:0] int_in;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] result;
  logic       ovf;
  logic       out_valid;
  logic       out_ready;

  typedef struct packed {
    logic [7:0] res;
    logic       ov;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  fixedpoint_inv dut (
    .clk       (clk),
    .rst       (rst),
    .int_in    (int_in),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .result    (result),
    .ovf       (ovf),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Monitor: every handshaken output is matched against the scoreboard
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_output: got result %0d expected none",
                 result);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("result", int'(result), int'(e.res));
        chk("ovf", int'(ovf), int'(e.ov));
      end
    end
  end

  task automatic wait_ready();
    int n;
    n = 0;
    while (!in_ready && n < 30) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (!in_ready) chk("in_ready_timeout", 0, 1);
  endtask

  // Issue one operand; returns once out_valid is seen (#1 after the edge)
  task automatic do_op(input logic [7:0] v, input logic [7:0] er,
                       input logic eo, input bit pulse);
    exp_t e;
    int   lat;
    wait_ready();
    e.res = er;
    e.ov  = eo;
    exp_q.push_back(e);
    int_in   = v;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    lat = 0;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk);
      #1;
      if (pulse && i == 3) begin
        int_in   = 8'd200;
        in_valid = 1'b1;
      end
      if (i == 4) in_valid = 1'b0;
      if (out_valid) begin
        lat = i;
        break;
      end
    end
    chk("latency", lat, 8);
  endtask

  initial begin
    rst       = 1'b1;
    int_in    = '0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", int'(in_ready), 1);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_result", int'(result), 0);
    chk("rst_ovf", int'(ovf), 0);
    rst = 1'b0;

    do_op(8'd22, 8'd32, 1'b0, 1'b0);
    do_op(8'd38, 8'd55, 1'b0, 1'b0);
    do_op(8'd7, 8'd10, 1'b0, 1'b0);
    do_op(8'd6, 8'd9, 1'b0, 1'b0);

    do_op(8'd0, 8'd0, 1'b0, 1'b0);
    do_op(8'd177, 8'd255, 1'b0, 1'b0);
    do_op(8'd178, 8'd255, 1'b1, 1'b0);
    do_op(8'd255, 8'd255, 1'b1, 1'b0);

    wait_ready();
    out_ready = 1'b0;
    do_op(8'd55, 8'd79, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      chk("bp_result", int'(result), 79);
      chk("bp_out_valid", int'(out_valid), 1);
      chk("bp_in_ready", int'(in_ready), 0);
      @(posedge clk);
      #1;
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("bp_release_in_ready", int'(in_ready), 1);

    do_op(8'd10, 8'd14, 1'b0, 1'b1);
    @(posedge clk);
    #1;
    chk("ignored_in_ready", int'(in_ready), 1);

    // Reset at cnt=4: accept edge, then four CALC edges
    wait_ready();
    int_in   = 8'd100;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("abort_in_ready", int'(in_ready), 1);
    chk("abort_out_valid", int'(out_valid), 0);
    chk("abort_result", int'(result), 0);
    do_op(8'd9, 8'd13, 1'b0, 1'b0);

    // Reset coincident with an accept attempt
    wait_ready();
    rst      = 1'b1;
    int_in   = 8'd50;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    rst      = 1'b0;
    in_valid = 1'b0;
    begin
      int seen;
      seen = 0;
      for (int i = 0; i < 10; i++) begin
        if (out_valid) seen++;
        @(posedge clk);
        #1;
      end
      chk("rstprio_out_valid_cycles", seen, 0);
    end
    chk("rstprio_in_ready", int'(in_ready), 1);

    repeat (3) @(posedge clk);
    #1;
    chk("scoreboard_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
